// File: rtl/dma_engine_core_v2.sv
// DMA engine core: CPU register file plus independent read and write burst FSMs
// that move dma_size bytes from src to dest through an external show-ahead FIFO.
module dma_engine_core_v2 #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int BURST_BEATS = 8,
    parameter  int FIFO_DEPTH  = 16,
    parameter  int RING_BYTES  = 4096,
    localparam int BPB         = DATA_WIDTH / 8,
    localparam int LEN_W       = $clog2(BURST_BEATS),
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           reg_wr_data,
    input  logic [5:0]            reg_wr_en,
    output logic [31:0]           src_base,
    output logic [31:0]           dest_base,
    output logic [31:0]           tail_ptr,
    output logic [31:0]           head_ptr,
    output logic [31:0]           dma_size,
    output logic [31:0]           ctrl_stat,
    output logic                  intr,
    output logic [31:0]           rd_req_addr,
    output logic [LEN_W-1:0]      rd_req_len,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    input  logic [DATA_WIDTH-1:0] rd_rdata,
    input  logic                  rd_valid,
    input  logic                  rd_last,
    output logic                  rd_ready,
    output logic [31:0]           wr_req_addr,
    output logic [LEN_W-1:0]      wr_req_len,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [BPB-1:0]        wr_strb,
    output logic                  wr_valid,
    output logic                  wr_last,
    input  logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_wen,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rden,
    input  logic                  fifo_empty,
    input  logic [CNT_W-1:0]      fifo_count
);
    localparam int BPB_W = $clog2(BPB);
    localparam int BC_W  = LEN_W + 1;
    localparam logic [BC_W-1:0] FULL_BURST = BC_W'(BURST_BEATS);
    localparam logic [BC_W-1:0] ONE_BEAT   = BC_W'(1);
    localparam logic [31:0]     RING_MASK  = 32'(RING_BYTES - 1);

    typedef enum logic [2:0] {RD_IDLE = 3'b001, RD_REQ = 3'b010, RD_DATA = 3'b100} rd_state_t;
    typedef enum logic [2:0] {WR_IDLE = 3'b001, WR_REQ = 3'b010, WR_DATA = 3'b100} wr_state_t;

    rd_state_t       rd_state_q, rd_state_d;
    wr_state_t       wr_state_q, wr_state_d;
    logic [31:0]     src_base_q, src_base_d, dest_base_q, dest_base_d;
    logic [31:0]     tail_ptr_q, tail_ptr_d, head_ptr_q, head_ptr_d;
    logic [31:0]     dma_size_q, dma_size_d, ctrl_stat_q, ctrl_stat_d;
    logic [31:0]     rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, size_lat_q, size_lat_d;
    logic [31:0]     rd_bursts_q, rd_bursts_d, wr_bursts_q, wr_bursts_d;
    logic [BC_W-1:0] last_beats_q, last_beats_d, rd_beats_q, rd_beats_d, wr_beats_q, wr_beats_d;
    logic            rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;

    logic            start_cond_s, start_s, err_s, done_s, final_beat_s, rd_space_ok_s;
    logic [32:0]     total_beats_s, num_bursts_s;
    logic [BC_W-1:0] rd_burst_beats_s, wr_burst_beats_s, new_last_s;
    logic [CNT_W-1:0] fifo_space_s;
    logic [BPB-1:0]  tail_strb_s;
    logic            unused_ok_s;

    assign start_cond_s = (rd_state_q == RD_IDLE) && (wr_state_q == WR_IDLE) &&
                          ctrl_stat_q[0] && (head_ptr_q != tail_ptr_q);
    assign start_s      = start_cond_s && (dma_size_q != 32'd0);
    assign err_s        = start_cond_s && (dma_size_q == 32'd0);

    // Burst geometry of a new transfer; the last burst holds the remainder beats.
    assign total_beats_s = (33'(dma_size_q) + 33'(BPB - 1)) >> BPB_W;
    assign num_bursts_s  = (total_beats_s + 33'(BURST_BEATS - 1)) >> LEN_W;
    assign new_last_s    = (total_beats_s[LEN_W-1:0] == {LEN_W{1'b0}}) ? FULL_BURST
                                                                       : {1'b0, total_beats_s[LEN_W-1:0]};

    assign rd_burst_beats_s = (rd_bursts_q == 32'd1) ? last_beats_q : FULL_BURST;
    assign wr_burst_beats_s = (wr_bursts_q == 32'd1) ? last_beats_q : FULL_BURST;
    assign fifo_space_s     = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign rd_space_ok_s    = 32'(fifo_space_s) >= 32'(rd_burst_beats_s);

    assign rd_req_valid = (rd_state_q == RD_REQ) && (rd_bursts_q != 32'd0) && (rd_space_ok_s || rd_pend_q);
    assign rd_req_addr  = rd_addr_q;
    assign rd_req_len   = LEN_W'(rd_burst_beats_s - ONE_BEAT);
    assign rd_ready     = (rd_state_q == RD_DATA);
    assign fifo_wen     = rd_valid && rd_ready;
    assign fifo_wdata   = rd_rdata;

    assign wr_req_valid = (wr_state_q == WR_REQ) && (wr_bursts_q != 32'd0) &&
                          ((fifo_count != {CNT_W{1'b0}}) || wr_pend_q);
    assign wr_req_addr  = wr_addr_q;
    assign wr_req_len   = LEN_W'(wr_burst_beats_s - ONE_BEAT);
    assign wr_valid     = (wr_state_q == WR_DATA) && !fifo_empty && (wr_beats_q != {BC_W{1'b0}});
    assign wr_last      = wr_valid && (wr_beats_q == ONE_BEAT);
    assign wr_data      = fifo_rdata;
    assign fifo_rden    = wr_valid && wr_ready;
    assign final_beat_s = (wr_state_q == WR_DATA) && (wr_bursts_q == 32'd1) && (wr_beats_q == ONE_BEAT);
    assign done_s       = fifo_rden && final_beat_s;
    assign wr_strb      = (final_beat_s && (size_lat_q[BPB_W-1:0] != {BPB_W{1'b0}})) ? tail_strb_s
                                                                                     : {BPB{1'b1}};

    assign src_base  = src_base_q;
    assign dest_base = dest_base_q;
    assign tail_ptr  = tail_ptr_q;
    assign head_ptr  = head_ptr_q;
    assign dma_size  = dma_size_q;
    assign ctrl_stat = ctrl_stat_q;
    assign intr      = ctrl_stat_q[31];
    assign unused_ok_s = ^{rd_last, num_bursts_s[32]};

    // Partial strobe for a transfer whose size is not a whole number of beats.
    always_comb begin
        tail_strb_s = {BPB{1'b0}};
        for (int i = 0; i < BPB; i++) begin
            tail_strb_s[i] = (32'(i) < 32'(size_lat_q[BPB_W-1:0]));
        end
    end

    // Next state: CPU writes, transfer launch, both channel FSMs and completion.
    always_comb begin
        src_base_d   = reg_wr_en[0] ? reg_wr_data : src_base_q;
        dest_base_d  = reg_wr_en[1] ? reg_wr_data : dest_base_q;
        tail_ptr_d   = reg_wr_en[2] ? reg_wr_data : tail_ptr_q;
        head_ptr_d   = reg_wr_en[3] ? reg_wr_data : head_ptr_q;
        dma_size_d   = reg_wr_en[4] ? reg_wr_data : dma_size_q;
        ctrl_stat_d  = reg_wr_en[5] ? {ctrl_stat_q[31] & ~reg_wr_data[31], reg_wr_data[30:0]} : ctrl_stat_q;
        rd_state_d   = rd_state_q;
        wr_state_d   = wr_state_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        size_lat_d   = size_lat_q;
        last_beats_d = last_beats_q;
        rd_bursts_d  = rd_bursts_q;
        wr_bursts_d  = wr_bursts_q;
        rd_beats_d   = rd_beats_q;
        wr_beats_d   = wr_beats_q;
        rd_pend_d    = rd_pend_q;
        wr_pend_d    = wr_pend_q;

        case (rd_state_q)
            RD_IDLE: begin
                if (start_s) begin
                    rd_state_d   = RD_REQ;
                    rd_addr_d    = src_base_q + tail_ptr_q;
                    rd_bursts_d  = num_bursts_s[31:0];
                    size_lat_d   = dma_size_q;
                    last_beats_d = new_last_s;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_REQ: begin
                if (rd_bursts_q == 32'd0) begin
                    rd_state_d = RD_IDLE;
                end else if (rd_req_valid && rd_req_ready) begin
                    rd_state_d  = RD_DATA;
                    rd_beats_d  = rd_burst_beats_s;
                    rd_addr_d   = rd_addr_q + (32'(rd_burst_beats_s) << BPB_W);
                    rd_bursts_d = rd_bursts_q - 32'd1;
                    rd_pend_d   = 1'b0;
                end else begin
                    rd_pend_d = rd_req_valid;
                end
            end
            RD_DATA: begin
                if (fifo_wen) begin
                    rd_beats_d = rd_beats_q - ONE_BEAT;
                    rd_state_d = (rd_beats_q == ONE_BEAT) ? RD_REQ : RD_DATA;
                end else begin
                    rd_state_d = RD_DATA;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        case (wr_state_q)
            WR_IDLE: begin
                if (start_s) begin
                    wr_state_d  = WR_REQ;
                    wr_addr_d   = dest_base_q + tail_ptr_q;
                    wr_bursts_d = num_bursts_s[31:0];
                end else begin
                    wr_state_d = WR_IDLE;
                end
            end
            WR_REQ: begin
                if (wr_bursts_q == 32'd0) begin
                    wr_state_d = WR_IDLE;
                end else if (wr_req_valid && wr_req_ready) begin
                    wr_state_d = WR_DATA;
                    wr_beats_d = wr_burst_beats_s;
                    wr_addr_d  = wr_addr_q + (32'(wr_burst_beats_s) << BPB_W);
                    wr_pend_d  = 1'b0;
                end else begin
                    wr_pend_d = wr_req_valid;
                end
            end
            WR_DATA: begin
                if (fifo_rden && (wr_beats_q == ONE_BEAT)) begin
                    wr_beats_d  = wr_beats_q - ONE_BEAT;
                    wr_bursts_d = wr_bursts_q - 32'd1;
                    wr_state_d  = WR_REQ;
                end else if (fifo_rden) begin
                    wr_beats_d = wr_beats_q - ONE_BEAT;
                end else begin
                    wr_state_d = WR_DATA;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        // Completion overrides any same-cycle CPU write of tail_ptr / intr.
        if (done_s) begin
            tail_ptr_d      = (tail_ptr_q + size_lat_q) & RING_MASK;
            ctrl_stat_d[31] = 1'b1;
            rd_state_d      = RD_IDLE;
            wr_state_d      = WR_IDLE;
            rd_bursts_d     = 32'd0;
            wr_bursts_d     = 32'd0;
            rd_pend_d       = 1'b0;
            wr_pend_d       = 1'b0;
        end else begin
            ctrl_stat_d[1] = ctrl_stat_d[1] | err_s;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q   <= RD_IDLE;
            wr_state_q   <= WR_IDLE;
            src_base_q   <= 32'd0;
            dest_base_q  <= 32'd0;
            tail_ptr_q   <= 32'd0;
            head_ptr_q   <= 32'd0;
            dma_size_q   <= 32'd0;
            ctrl_stat_q  <= 32'd0;
            rd_addr_q    <= 32'd0;
            wr_addr_q    <= 32'd0;
            size_lat_q   <= 32'd0;
            last_beats_q <= {BC_W{1'b0}};
            rd_bursts_q  <= 32'd0;
            wr_bursts_q  <= 32'd0;
            rd_beats_q   <= {BC_W{1'b0}};
            wr_beats_q   <= {BC_W{1'b0}};
            rd_pend_q    <= 1'b0;
            wr_pend_q    <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            wr_state_q   <= wr_state_d;
            src_base_q   <= src_base_d;
            dest_base_q  <= dest_base_d;
            tail_ptr_q   <= tail_ptr_d;
            head_ptr_q   <= head_ptr_d;
            dma_size_q   <= dma_size_d;
            ctrl_stat_q  <= ctrl_stat_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            size_lat_q   <= size_lat_d;
            last_beats_q <= last_beats_d;
            rd_bursts_q  <= rd_bursts_d;
            wr_bursts_q  <= wr_bursts_d;
            rd_beats_q   <= rd_beats_d;
            wr_beats_q   <= wr_beats_d;
            rd_pend_q    <= rd_pend_d;
            wr_pend_q    <= wr_pend_d;
        end
    end
endmodule

// File: tb/tb_dma_engine_core_v2.sv
// Directed bench for dma_engine_core_v2: FIFO, read-memory and write-sink models,
// request/beat logs, and hand-computed expectations checked with immediate assertions.
module tb_dma_engine_core_v2;
    localparam int LW = 3;
    localparam int CW = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] reg_wr_data;
    logic [5:0]  reg_wr_en;
    logic [31:0] src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat;
    logic        intr;
    logic [31:0] rd_req_addr, wr_req_addr;
    logic [LW-1:0] rd_req_len, wr_req_len;
    logic        rd_req_valid, rd_req_ready, rd_valid, rd_last, rd_ready;
    logic [31:0] rd_rdata, wr_data, fifo_wdata, fifo_rdata;
    logic        wr_req_valid, wr_req_ready, wr_valid, wr_last, wr_ready;
    logic [3:0]  wr_strb;
    logic        fifo_wen, fifo_rden, fifo_empty;
    logic [CW-1:0] fifo_count;

    int total = 0;
    int bad   = 0;

    dma_engine_core_v2 #(.DATA_WIDTH(32), .BURST_BEATS(8), .FIFO_DEPTH(16), .RING_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
        .src_base(src_base), .dest_base(dest_base), .tail_ptr(tail_ptr), .head_ptr(head_ptr),
        .dma_size(dma_size), .ctrl_stat(ctrl_stat), .intr(intr),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_rdata(rd_rdata), .rd_valid(rd_valid), .rd_last(rd_last),
        .rd_ready(rd_ready), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_data(wr_data),
        .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
        .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen), .fifo_rdata(fifo_rdata),
        .fifo_rden(fifo_rden), .fifo_empty(fifo_empty), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model with an optional override of the reported count.
    logic [31:0]   fmem [16];
    logic [3:0]    fwp, frp;
    logic [CW-1:0] fcnt;
    logic          cnt_force_en;
    logic [CW-1:0] cnt_force_val;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwp <= 4'd0; frp <= 4'd0; fcnt <= 5'd0;
        end else begin
            if (fifo_wen) begin
                fmem[fwp] <= fifo_wdata;
                fwp <= fwp + 4'd1;
            end
            if (fifo_rden) frp <= frp + 4'd1;
            fcnt <= fcnt + {4'd0, fifo_wen} - {4'd0, fifo_rden};
        end
    end
    assign fifo_count = cnt_force_en ? cnt_force_val : fcnt;
    assign fifo_empty = (fcnt == 5'd0);
    assign fifo_rdata = fmem[frp];

    // Source memory: data word = byte address ^ 0x5A5A0000.
    logic [31:0] rs_addr;
    logic [4:0]  rs_rem;
    assign rd_valid = (rs_rem != 5'd0);
    assign rd_last  = (rs_rem == 5'd1);
    assign rd_rdata = rs_addr ^ 32'h5A5A_0000;

    logic [31:0] rq_addr_a [256];
    logic [31:0] rq_len_a  [256];
    logic [31:0] wq_addr_a [256];
    logic [31:0] wq_len_a  [256];
    logic [31:0] wb_data_a [256];
    logic [31:0] wb_strb_a [256];
    logic [31:0] wb_last_a [256];
    int rq_n = 0, wq_n = 0, wb_n = 0;

    // Read responder and request/beat logging.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_rem <= 5'd0; rs_addr <= 32'd0;
        end else begin
            if (rd_req_valid && rd_req_ready) begin
                rs_addr <= rd_req_addr;
                rs_rem  <= {2'b00, rd_req_len} + 5'd1;
                if (rq_n < 256) begin rq_addr_a[rq_n] = rd_req_addr; rq_len_a[rq_n] = 32'(rd_req_len); rq_n++; end
            end else if (rd_valid && rd_ready) begin
                rs_addr <= rs_addr + 32'd4;
                rs_rem  <= rs_rem - 5'd1;
            end
            if (wr_req_valid && wr_req_ready && wq_n < 256) begin
                wq_addr_a[wq_n] = wr_req_addr; wq_len_a[wq_n] = 32'(wr_req_len); wq_n++;
            end
            if (wr_valid && wr_ready && wb_n < 256) begin
                wb_data_a[wb_n] = wr_data; wb_strb_a[wb_n] = 32'(wr_strb); wb_last_a[wb_n] = 32'(wr_last); wb_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wreg(input int idx, input logic [31:0] d);
        reg_wr_en   = 6'd1 << idx;
        reg_wr_data = d;
        tick(1);
        reg_wr_en   = 6'd0;
    endtask

    task automatic wait_intr(input string tag);
        int n = 0;
        while (intr !== 1'b1 && n < 400) begin tick(1); n++; end
        chk(tag, 32'(intr), 32'd1);
    endtask

    int rb, wb_b, wqb;

    initial begin
        rst_n = 1'b0; reg_wr_data = 32'd0; reg_wr_en = 6'd0;
        rd_req_ready = 1'b1; wr_req_ready = 1'b1; wr_ready = 1'b1;
        cnt_force_en = 1'b0; cnt_force_val = 5'd0;
        tick(2);
        chk("rst_ctrl", ctrl_stat, 32'd0);
        chk("rst_tail", tail_ptr, 32'd0);
        chk("rst_rdv", 32'(rd_req_valid), 32'd0);
        chk("rst_intr", 32'(intr), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_wrv", 32'(wr_req_valid), 32'd0);

        // 64-byte transfer: two full bursts
        rb = rq_n; wqb = wq_n; wb_b = wb_n;
        wreg(0, 32'h1000); wreg(1, 32'h2000); wreg(3, 32'd64); wreg(4, 32'd64); wreg(5, 32'd1);
        wait_intr("t64_done");
        chk("t64_nrq", 32'(rq_n - rb), 32'd2);
        chk("t64_rq0", rq_addr_a[rb], 32'h1000);
        chk("t64_len0", rq_len_a[rb], 32'd7);
        chk("t64_rq1", rq_addr_a[rb+1], 32'h1020);
        chk("t64_len1", rq_len_a[rb+1], 32'd7);
        chk("t64_wq0", wq_addr_a[wqb], 32'h2000);
        chk("t64_wq1", wq_addr_a[wqb+1], 32'h2020);
        chk("t64_nwb", 32'(wb_n - wb_b), 32'd16);
        chk("t64_d15", wb_data_a[wb_b+15], 32'h5A5A_103C);
        chk("t64_strb", wb_strb_a[wb_b+15], 32'hF);
        chk("t64_tail", tail_ptr, 32'd64);
        tick(3);
        chk("t64_norestart", 32'(rd_req_valid), 32'd0);

        // 70-byte transfer, CPU edits during transfer, enable dropped mid-way
        wreg(5, 32'h8000_0000);
        chk("clr_intr", 32'(intr), 32'd0);
        rb = rq_n; wqb = wq_n; wb_b = wb_n;
        wreg(2, 32'd0); wreg(3, 32'd128); wreg(4, 32'd70); wreg(1, 32'h3000); wreg(5, 32'd1);
        tick(3);
        wreg(4, 32'd4); wreg(0, 32'hDEAD_0000); wreg(5, 32'd0);
        wait_intr("t70_done");
        chk("t70_nrq", 32'(rq_n - rb), 32'd3);
        chk("t70_rq2", rq_addr_a[rb+2], 32'h1040);
        chk("t70_len2", rq_len_a[rb+2], 32'd1);
        chk("t70_wq2", wq_addr_a[wqb+2], 32'h3040);
        chk("t70_wlen2", wq_len_a[wqb+2], 32'd1);
        chk("t70_nwb", 32'(wb_n - wb_b), 32'd18);
        chk("t70_strb16", wb_strb_a[wb_b+16], 32'hF);
        chk("t70_strb17", wb_strb_a[wb_b+17], 32'h3);
        chk("t70_last7", wb_last_a[wb_b+7], 32'd1);
        chk("t70_last16", wb_last_a[wb_b+16], 32'd0);
        chk("t70_last17", wb_last_a[wb_b+17], 32'd1);
        chk("t70_d17", wb_data_a[wb_b+17], 32'h5A5A_1044);
        chk("t70_tail", tail_ptr, 32'd70);
        chk("t70_ctrl", ctrl_stat, 32'h8000_0000);
        tick(3);
        chk("t70_nochain", 32'(rq_n - rb), 32'd3);

        // zero size -> error bit, no transfer
        wreg(5, 32'h8000_0000); wreg(4, 32'd0); wreg(5, 32'd1);
        tick(2);
        chk("err_ctrl", ctrl_stat, 32'h0000_0003);
        chk("err_rdv", 32'(rd_req_valid), 32'd0);
        chk("err_tail", tail_ptr, 32'd70);

        // FIFO space gating of read requests
        wreg(5, 32'h8000_0000);
        rb = rq_n; wqb = wq_n;
        wreg(2, 32'd0); wreg(3, 32'd32); wreg(4, 32'd32); wreg(0, 32'h1000); wreg(1, 32'h2000);
        rd_req_ready = 1'b0; wr_req_ready = 1'b0; cnt_force_en = 1'b1; cnt_force_val = 5'd10;
        wreg(5, 32'd1);
        tick(3);
        chk("fifo10_rdv", 32'(rd_req_valid), 32'd0);
        cnt_force_val = 5'd8;
        #1;
        chk("fifo8_rdv", 32'(rd_req_valid), 32'd1);
        chk("fifo8_addr", rd_req_addr, 32'h1000);
        chk("fifo8_len", 32'(rd_req_len), 32'd7);
        chk("fifo8_wrv", 32'(wr_req_valid), 32'd1);
        tick(1);
        cnt_force_val = 5'd10;
        tick(2);
        chk("fifo_hold", 32'(rd_req_valid), 32'd1);
        cnt_force_en = 1'b0; rd_req_ready = 1'b1; wr_req_ready = 1'b1;
        wait_intr("fifo_done");
        chk("fifo_tail", tail_ptr, 32'd32);
        chk("fifo_nrq", 32'(rq_n - rb), 32'd1);
        chk("fifo_wq0", wq_addr_a[wqb], 32'h2000);

        // ring wrap
        wreg(5, 32'h8000_0000);
        rb = rq_n; wqb = wq_n;
        wreg(2, 32'd224); wreg(3, 32'd0); wreg(4, 32'd32); wreg(5, 32'd1);
        wait_intr("wrap_done");
        chk("wrap_tail", tail_ptr, 32'd0);
        chk("wrap_rq0", rq_addr_a[rb], 32'h10E0);
        chk("wrap_wq0", wq_addr_a[wqb], 32'h20E0);

        // auto-chain with intr cleared in between
        wreg(5, 32'h8000_0000);
        rb = rq_n; wqb = wq_n;
        wreg(3, 32'd128); wreg(4, 32'd64); wreg(5, 32'd1);
        wait_intr("chain1_done");
        chk("chain1_tail", tail_ptr, 32'd64);
        wreg(5, 32'h8000_0001);
        chk("chain_clr", 32'(intr), 32'd0);
        wait_intr("chain2_done");
        chk("chain2_tail", tail_ptr, 32'd128);
        chk("chain_nrq", 32'(rq_n - rb), 32'd4);
        chk("chain_rq2", rq_addr_a[rb+2], 32'h1040);
        chk("chain_wq3", wq_addr_a[wqb+3], 32'h2060);

        // reset in the middle of a write burst
        wreg(3, 32'd192);
        begin
            int n = 0;
            while (wr_valid !== 1'b1 && n < 200) begin tick(1); n++; end
            chk("rst_mid_wrv_pre", 32'(wr_valid), 32'd1);
        end
        chk("rst_mid_intr_pre", 32'(intr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wrv", 32'(wr_valid), 32'd0);
        chk("rst_mid_rdv", 32'(rd_req_valid), 32'd0);
        chk("rst_mid_intr", 32'(intr), 32'd0);
        chk("rst_mid_head", head_ptr, 32'd0);
        chk("rst_mid_tail", tail_ptr, 32'd0);
        chk("rst_mid_src", src_base, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_rdv", 32'(rd_req_valid), 32'd0);
        chk("post_rst_ctrl", ctrl_stat, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
